conv_encoder_sys: RTL and testbench

- Rate-1/2 convolutional encoder; the transmit-side counterpart of the Viterbi decoder_sys.
- Accepts a bit-serial data frame and emits one 2-bit symbol per input bit, then K-1 zero-input tail symbols so the trellis ends in state 0.
- Constraint length K is selectable from 3 to 6, using the same generator set the decoder expects.
- Sits between the framing logic and the channel/decoder path; valid/ready on both sides.

---
 rtl/conv_encoder_sys.sv | 144 ++++++++++++++
 tb/tb_conv_encoder_sys.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_sys.sv
// Rate-1/2 convolutional encoder, K selectable 3..6, with zero-input tail flush.
// Optional symbol counter / frame_done outputs enabled by CONV_ENC_SYM_COUNT_EN.
module conv_encoder_sys #(
  parameter int MAX_K = 6,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] choose_constraint_length,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] encoded_bits,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
`ifdef CONV_ENC_SYM_COUNT_EN
  ,
  output logic [CNT_W-1:0] sym_count,
  output logic             frame_done
`endif
);

  localparam int SR_W = MAX_K - 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_k, w_k_sel, w_k_cur;
  logic [2:0]      r_tail_cnt, w_tail_nxt;
  logic [SR_W-1:0] r_sr, w_sr_nxt, w_sr_mask;
  logic [1:0]      r_enc, w_sym;
  logic            r_out_valid, r_out_last;
  logic            w_load, w_acc, w_tail_step, w_u, w_emit;

  // Octal generator for the given K; MSB taps the current input bit.
  function automatic logic [MAX_K-1:0] gen_poly(input logic [2:0] k, input logic sel_g1);
    case (k)
      3'd3:    return sel_g1 ? MAX_K'(6'o05) : MAX_K'(6'o07);
      3'd4:    return sel_g1 ? MAX_K'(6'o17) : MAX_K'(6'o15);
      3'd5:    return sel_g1 ? MAX_K'(6'o35) : MAX_K'(6'o23);
      default: return sel_g1 ? MAX_K'(6'o75) : MAX_K'(6'o53);
    endcase
  endfunction

  // Left-align the generator so bit MAX_K-1-j always taps s_j regardless of K.
  function automatic logic tap_parity(input logic [2:0] k, input logic sel_g1,
                                      input logic u, input logic [SR_W-1:0] sr);
    logic [MAX_K-1:0] g_al;
    logic             p;
    g_al = gen_poly(k, sel_g1) << (MAX_K - int'(k));
    p    = u;
    for (int j = 1; j < MAX_K; j++) p = p ^ (g_al[MAX_K-1-j] & sr[j-1]);
    return p;
  endfunction

  assign w_k_sel = (choose_constraint_length < 3'd3) ? 3'd3 :
                   (choose_constraint_length > 3'd6) ? 3'd6 : choose_constraint_length;
  assign w_k_cur = (r_state == S_IDLE) ? w_k_sel : r_k;

  assign w_load      = !r_out_valid || out_ready;
  assign in_ready    = rst_n && (r_state != S_TAIL) && w_load;
  assign w_acc       = in_valid && in_ready;
  assign w_tail_step = (r_state == S_TAIL) && w_load;
  assign w_emit      = w_acc || w_tail_step;
  assign w_u         = w_acc ? in_bit : 1'b0;

  assign w_sym     = {tap_parity(w_k_cur, 1'b0, w_u, r_sr), tap_parity(w_k_cur, 1'b1, w_u, r_sr)};
  // K=6 wraps 1<<5 to zero, so the subtraction yields all ones as intended.
  assign w_sr_mask = (SR_W'(1) << (w_k_cur - 3'd1)) - SR_W'(1);
  assign w_sr_nxt  = {r_sr[SR_W-2:0], w_u} & w_sr_mask;

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_tail_nxt  = r_tail_cnt;
    case (r_state)
      S_IDLE: if (w_acc) begin
        w_state_nxt = in_last ? S_TAIL : S_DATA;
        if (in_last) w_tail_nxt = w_k_sel - 3'd1;
      end
      S_DATA: if (w_acc && in_last) begin
        w_state_nxt = S_TAIL;
        w_tail_nxt  = r_k - 3'd1;
      end
      S_TAIL: if (w_load) begin
        w_tail_nxt = r_tail_cnt - 3'd1;
        if (r_tail_cnt == 3'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tail_cnt  <= 3'd0;
      r_k         <= 3'd3;
      r_sr        <= '0;
      r_enc       <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tail_cnt <= w_tail_nxt;
      if (r_state == S_IDLE && w_acc) r_k <= w_k_sel;
      if (w_emit) r_sr <= w_sr_nxt;
      if (w_load) begin
        r_out_valid <= w_emit;
        r_enc       <= w_emit ? w_sym : 2'b00;
        r_out_last  <= w_tail_step && (r_tail_cnt == 3'd1);
      end
    end
  end

  assign encoded_bits = r_enc;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;

`ifdef CONV_ENC_SYM_COUNT_EN
  logic [CNT_W-1:0] r_sym_count;
  logic             r_frame_done;
  logic             w_hs;

  assign w_hs = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_count  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_hs && r_out_last;
      if (r_state == S_IDLE && w_acc)       r_sym_count <= '0;
      else if (w_hs && (r_sym_count != '1)) r_sym_count <= r_sym_count + 1'b1;
    end
  end

  assign sym_count  = r_sym_count;
  assign frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_conv_encoder_sys.sv
// Self-checking bench for conv_encoder_sys: vector table, hand-written corner cases,
// and randomized frames checked against a convolution reference model.
module tb_conv_encoder_sys;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] choose_constraint_length = 3'd3;
  logic       in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, out_last;
  logic [1:0] encoded_bits;
`ifdef CONV_ENC_SYM_COUNT_EN
  logic [15:0] sym_count;
  logic        frame_done;
`endif

  conv_encoder_sys dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .choose_constraint_length (choose_constraint_length),
    .in_bit                   (in_bit),
    .in_valid                 (in_valid),
    .in_last                  (in_last),
    .in_ready                 (in_ready),
    .encoded_bits             (encoded_bits),
    .out_valid                (out_valid),
    .out_last                 (out_last),
    .out_ready                (out_ready)
`ifdef CONV_ENC_SYM_COUNT_EN
    ,
    .sym_count                (sym_count),
    .frame_done               (frame_done)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Table record: bits[i] is data bit i; syms[2i+1:2i] is expected symbol i.
  typedef struct {
    int          k;
    int          n;
    logic [15:0] bits;
    int          nsym;
    logic [31:0] syms;
    bit          stall;
  } vec_t;

  bit         fb[$];     // frame data bits
  logic [2:0] got[$];    // {last, symbol} per output handshake
  logic [2:0] expq[$];

  function automatic int gen_oct(input int k, input int which);
    case (k)
      3:       return which ? 'o5  : 'o7;
      4:       return which ? 'o17 : 'o15;
      5:       return which ? 'o35 : 'o23;
      default: return which ? 'o75 : 'o53;
    endcase
  endfunction

  function automatic int clamp_k(input int k);
    return (k < 3) ? 3 : (k > 6) ? 6 : k;
  endfunction

  // Reference: y_g(t) = XOR over j of g_j * u(t-j), u padded with K-1 zeros.
  task automatic build_expected(input int k);
    int n = fb.size();
    expq.delete();
    for (int t = 0; t < n + k - 1; t++) begin
      logic [1:0] s;
      for (int w = 0; w < 2; w++) begin
        int g = gen_oct(k, w);
        bit p = 0;
        for (int j = 0; j < k; j++)
          if (((g >> (k - 1 - j)) & 1) == 1 && t - j >= 0 && t - j < n) p ^= fb[t-j];
        s[1-w] = p;
      end
      expq.push_back({(t == n + k - 2), s});
    end
  endtask

  task automatic compare_model(input string name);
    check({name, "_len"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      check($sformatf("%s_sym%0d", name, i), got[i], expq[i]);
  endtask

  task automatic compare_vec(input string name, input vec_t v);
    check({name, "_len"}, got.size(), v.nsym);
    for (int i = 0; i < got.size() && i < v.nsym; i++) begin
      check($sformatf("%s_sym%0d", name, i), got[i][1:0], v.syms[2*i +: 2]);
      check($sformatf("%s_last%0d", name, i), got[i][2], (i == v.nsym - 1));
    end
  endtask

  // Drives fb as one frame and collects symbols; called and returns at a negedge.
  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_frame(input int k_in, input int ready_mode, input bit gaps, input bit b2b);
    int         idx = 0;
    int         cyc = 0;
    int         n = fb.size();
    bit         done = 0, pending = 0, stalled = 0, acc;
    logic [1:0] held = 2'b00;
    got.delete();
    while (!done && cyc < 2000) begin
      if (!pending) begin
        in_valid = (idx < n) && (!gaps || $urandom_range(3) != 0);
        in_bit   = (idx < n) ? fb[idx] : 1'b0;
        in_last  = (idx == n - 1);
      end
      choose_constraint_length = (idx == 0) ? 3'(k_in) : 3'($urandom_range(7));
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(1));
      endcase
      #1;
      if (stalled) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_sym_hold", encoded_bits, held);
      end
      if (cyc == 0 && b2b) check("b2b_in_ready", in_ready, 1);
      stalled = out_valid && !out_ready;
      if (stalled) begin
        check("stall_in_ready", in_ready, 0);
        held = encoded_bits;
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got.push_back({out_last, encoded_bits});
        if (out_last) done = 1;
      end
      @(posedge clk);
      if (acc) idx++;
      pending = in_valid && !acc;
      @(negedge clk);
      cyc++;
    end
    if (!done) check("frame_timeout", 0, 1);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic load_vec(input vec_t v);
    fb.delete();
    for (int i = 0; i < v.n; i++) fb.push_back(v.bits[i]);
  endtask

`ifdef CONV_ENC_SYM_COUNT_EN
  int fd_cnt = 0;
  always @(negedge clk) if (frame_done) fd_cnt++;
`endif

  vec_t vecs[3];

  initial begin
    // 1,0,1,1 at K=3 -> 11,10,00,01,01,11 ; impulse at K=4 -> 11,11,01,11
    vecs[0] = '{k: 3, n: 4, bits: 16'b1101, nsym: 6, syms: 32'h0000_0D4B, stall: 0};
    vecs[1] = '{k: 4, n: 1, bits: 16'b0001, nsym: 4, syms: 32'h0000_00DF, stall: 0};
    vecs[2] = '{k: 3, n: 4, bits: 16'b1101, nsym: 6, syms: 32'h0000_0D4B, stall: 1};

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_encoded", encoded_bits, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      load_vec(vecs[i]);
      run_frame(vecs[i].k, vecs[i].stall ? 1 : 0, 1'b0, (i == 1));
      compare_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // K select 7 clamps to 6; random mid-frame selects must be ignored.
    fb.delete();
    for (int i = 0; i < 8; i++) fb.push_back(1'($urandom_range(1)));
    run_frame(7, 0, 1'b0, 1'b0);
    build_expected(6);
    check("k7_total_syms", got.size(), 13);
    compare_model("k7");

    // Reset asserted while a K=5 frame is in its tail.
    choose_constraint_length = 3'd5;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = (i != 2);
      in_last  = (i == 2);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("tail_in_ready", in_ready, 0);
    check("tail_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_last", out_last, 0);
    check("async_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_vec(vecs[0]);
    run_frame(3, 0, 1'b0, 1'b0);
    compare_vec("post_rst", vecs[0]);

    // Randomized frames against the reference model.
    for (int f = 0; f < 30; f++) begin
      int k_sel = $urandom_range(7);
      int n     = $urandom_range(24, 1);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(1'($urandom_range(1)));
      run_frame(k_sel, 2, 1'b1, 1'b0);
      build_expected(clamp_k(k_sel));
      compare_model($sformatf("rnd%0d_k%0d", f, k_sel));
    end

`ifdef CONV_ENC_SYM_COUNT_EN
    fb.delete();
    for (int i = 0; i < 10; i++) fb.push_back(1'($urandom_range(1)));
    fd_cnt = 0;
    run_frame(5, 0, 1'b0, 1'b0);
    check("cnt_final", sym_count, 14);
    check("frame_done_pulse", frame_done, 1);
    @(negedge clk);
    check("frame_done_clear", frame_done, 0);
    check("frame_done_once", fd_cnt, 1);
    choose_constraint_length = 3'd3;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    in_last   = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("cnt_restart", sym_count, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("cnt_first_hs", sym_count, 1);
    begin
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        if (out_valid && out_last) seen = 1;
        @(posedge clk);
        @(negedge clk);
      end
      check("cnt_drain_seen", seen, 1);
    end
    check("cnt_short_frame", sym_count, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
